// File: rtl/adder_station_if.sv
// adder_station_if: instruction issue, operand fetch and result buses of one
// adder reservation station.
interface adder_station_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 4,
    parameter int FU_INDEX  = 4
);
    logic [FU_INDEX-1:0]          CDB_inst_fu;
    logic [WORD_SIZE-1:0]         CDB_inst_inst;
    logic [RB_INDEX-1:0]          CDB_inst_RBindex;
    logic [WORD_SIZE-1:0]         vj;
    logic [WORD_SIZE-1:0]         vk;
    logic [RB_INDEX-1:0]          qj;
    logic [RB_INDEX-1:0]          qk;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic                         busy;
    logic [WORD_SIZE-1:0]         result_data;
    logic [RB_INDEX-1:0]          result_index;
    logic                         result_valid;

    modport master (
        output CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex, vj, vk, qj, qk,
               CDB_data_data, CDB_data_valid,
        input  busy, result_data, result_index, result_valid
    );

    modport slave (
        input  CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex, vj, vk, qj, qk,
               CDB_data_data, CDB_data_valid,
        output busy, result_data, result_index, result_valid
    );
endinterface

// File: rtl/adder_station.sv
// adder_station: single-entry reservation station feeding an add/subtract unit;
// issues from the instruction bus and snoops the data bus for pending operands.
module adder_station #(
    parameter int                  WORD_SIZE   = 32,
    parameter int                  RB_SIZE     = 8,
    parameter int                  RB_INDEX    = 4,
    parameter int                  REG_INDEX   = 5,
    parameter int                  FU_INDEX    = 4,
    parameter logic [FU_INDEX-1:0] FU_ID       = '0,
    parameter logic [RB_INDEX-1:0] READY       = '1,
    parameter int                  ADD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fu_reset,
    adder_station_if.slave       bus,
    output wire  [REG_INDEX-1:0] numj,
    output wire  [REG_INDEX-1:0] numk
);
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_SUBI = 4'd4;
    localparam int RB_W  = $clog2(RB_SIZE);
    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

    state_t               r_state, w_state_n;
    logic [3:0]           r_op, w_op;
    logic [RB_INDEX-1:0]  r_tag, r_qj, r_qk, w_tag, w_qj, w_qk;
    logic [WORD_SIZE-1:0] r_vj, r_vk, r_result, w_vj, w_vk, w_sj, w_sk, w_calc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_rst, w_busy, w_accept, w_imm, w_hj, w_hk, w_ready, w_last;
    logic                 w_unused;

    // A slot is taken only for a real pending tag, never for our own destination tag.
    function automatic logic snoop(input logic [RB_INDEX-1:0] q, input logic [RB_INDEX-1:0] t,
                                   input logic [RB_SIZE-1:0] v);
        return q != READY && int'(q) < RB_SIZE && q != t && v[q[RB_W-1:0]];
    endfunction

    assign w_rst    = reset | fu_reset;
    assign w_busy   = r_state == WAIT || r_state == EXEC;
    assign w_accept = bus.CDB_inst_fu == FU_ID && !w_busy;
    assign w_imm    = bus.CDB_inst_inst[31:28] == OP_ADDI || bus.CDB_inst_inst[31:28] == OP_SUBI;
    assign w_unused = ^bus.CDB_inst_inst[27:23];
    assign numj     = w_accept ? bus.CDB_inst_inst[22:18] : 'z;
    assign numk     = w_accept ? bus.CDB_inst_inst[17:13] : 'z;

    // Operands as they stand before this edge's bus snoop: fresh on issue, held otherwise.
    assign w_op  = w_accept ? bus.CDB_inst_inst[31:28] : r_op;
    assign w_tag = w_accept ? bus.CDB_inst_RBindex : r_tag;
    assign w_qj  = w_accept ? bus.qj : r_qj;
    assign w_vj  = w_accept ? bus.vj : r_vj;
    assign w_qk  = w_accept ? (w_imm ? READY : bus.qk) : r_qk;
    assign w_vk  = w_accept ? (w_imm ? {{(WORD_SIZE-13){bus.CDB_inst_inst[12]}}, bus.CDB_inst_inst[12:0]}
                                     : bus.vk) : r_vk;

    assign w_hj    = snoop(w_qj, w_tag, bus.CDB_data_valid);
    assign w_hk    = snoop(w_qk, w_tag, bus.CDB_data_valid);
    assign w_sj    = bus.CDB_data_data[int'(w_qj[RB_W-1:0]) * WORD_SIZE +: WORD_SIZE];
    assign w_sk    = bus.CDB_data_data[int'(w_qk[RB_W-1:0]) * WORD_SIZE +: WORD_SIZE];
    assign w_ready = (w_hj || w_qj == READY) && (w_hk || w_qk == READY);
    assign w_last  = r_cnt == CNT_W'(ADD_LATENCY - 1);
    assign w_calc  = (r_op == OP_ADD || r_op == OP_ADDI) ? r_vj + r_vk :
                     (r_op == OP_SUB || r_op == OP_SUBI) ? r_vj - r_vk : '0;

    always_comb begin
        w_state_n = r_state;
        if (r_state == IDLE || r_state == DONE)
            w_state_n = w_accept ? (w_ready ? EXEC : WAIT) : IDLE;
        else if (r_state == WAIT)
            w_state_n = w_ready ? EXEC : WAIT;
        else
            w_state_n = w_last ? DONE : EXEC;
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_tag    <= '0;
            r_qj     <= READY;
            r_qk     <= READY;
            r_vj     <= '0;
            r_vk     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_n;
            r_op     <= w_op;
            r_tag    <= w_tag;
            r_qj     <= w_hj ? READY : w_qj;
            r_qk     <= w_hk ? READY : w_qk;
            r_vj     <= w_hj ? w_sj : w_vj;
            r_vk     <= w_hk ? w_sk : w_vk;
            r_cnt    <= r_state == EXEC ? r_cnt + 1'b1 : '0;
            r_result <= (r_state == EXEC && w_last) ? w_calc : r_result;
        end
    end

    assign bus.busy         = w_busy;
    assign bus.result_valid = r_state == DONE;
    assign bus.result_data  = r_result;
    assign bus.result_index = r_tag;
endmodule

// File: tb/tb_adder_station.sv
// tb_adder_station: directed-vector bench for the adder reservation station.
module tb_adder_station;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_SUBI = 4'd4;
    localparam logic [3:0] RDY     = 4'hF;
    localparam logic [3:0] NONE    = 4'hE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fu_reset = 1'b0;
    wire [4:0] numj, numk;
    int n_pass = 0;
    int n_total = 0;

    logic [3:0]  a_op  [5] = '{OP_SUBI, OP_ADD, OP_SUB, OP_ADDI, OP_ADDI};
    logic [31:0] a_vj  [5] = '{32'd0, 32'hFFFFFFFF, 32'd3, 32'h20, 32'd100};
    logic [31:0] a_vk  [5] = '{32'hDEAD, 32'd1, 32'd5, 32'hDEAD, 32'hDEAD};
    logic [12:0] a_imm [5] = '{13'h1FFF, 13'd0, 13'd0, 13'h0010, 13'h1000};
    logic [31:0] a_exp [5] = '{32'h1, 32'h0, 32'hFFFFFFFE, 32'h30, 32'hFFFFF064};

    adder_station_if #(.WORD_SIZE(32), .RB_SIZE(8), .RB_INDEX(4), .FU_INDEX(4)) bus ();

    adder_station #(
        .WORD_SIZE(32), .RB_SIZE(8), .RB_INDEX(4), .REG_INDEX(5), .FU_INDEX(4),
        .FU_ID(4'd0), .READY(4'hF), .ADD_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fu_reset(fu_reset),
        .bus(bus),
        .numj(numj),
        .numk(numk)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [12:0] imm);
        return {op, 5'd0, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] fu, input logic [31:0] inst, input logic [3:0] tag,
                         input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk);
        bus.CDB_inst_fu      = fu;
        bus.CDB_inst_inst    = inst;
        bus.CDB_inst_RBindex = tag;
        bus.vj = vj;
        bus.qj = qj;
        bus.vk = vk;
        bus.qk = qk;
    endtask

    task automatic slot(input int s, input logic [31:0] d, input logic v);
        bus.CDB_data_data[s*32 +: 32] = d;
        bus.CDB_data_valid[s] = v;
    endtask

    task automatic test_reset;
        bus.CDB_data_data  = '0;
        bus.CDB_data_valid = '0;
        issue(NONE, mk(OP_ADD, 5'd1, 5'd2, 13'd0), 4'd0, 32'd0, RDY, 32'd0, RDY);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid, bus.result_data, bus.result_index} !== 38'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.busy, bus.result_valid, bus.result_data, bus.result_index});
        else n_pass++;
        n_total++;
        if (numj === 5'd1) $display("FAIL reset_numj: got %b want z", numj);
        else n_pass++;
        n_total++;
        if (numk === 5'd2) $display("FAIL reset_numk: got %b want z", numk);
        else n_pass++;
    endtask

    task automatic test_add;
        issue(4'd0, mk(OP_ADD, 5'd1, 5'd2, 13'd0), 4'd3, 32'd5, RDY, 32'd7, RDY);
        #1;
        n_total++;
        if ({numj, numk} !== {5'd1, 5'd2}) $display("FAIL add_num: got %h want %h", {numj, numk}, {5'd1, 5'd2});
        else n_pass++;
        tick();
        bus.CDB_inst_fu = NONE;
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b10) $display("FAIL add_t0: got %b want 10", {bus.busy, bus.result_valid});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b10) $display("FAIL add_t1: got %b want 10", {bus.busy, bus.result_valid});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid, bus.result_data, bus.result_index} !== {1'b0, 1'b1, 32'd12, 4'd3})
            $display("FAIL add_t2: got %h want %h", {bus.busy, bus.result_valid, bus.result_data, bus.result_index},
                     {1'b0, 1'b1, 32'd12, 4'd3});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b00) $display("FAIL add_t3: got %b want 00", {bus.busy, bus.result_valid});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            issue(4'd0, mk(a_op[i], 5'd4, 5'd5, a_imm[i]), 4'(i + 1), a_vj[i], RDY, a_vk[i],
                  (a_op[i] == OP_ADDI) ? 4'd2 : RDY);
            tick();
            bus.CDB_inst_fu = NONE;
            n_total++;
            if (bus.busy !== 1'b1) $display("FAIL b2b_busy_%0d: got %b want 1", i, bus.busy);
            else n_pass++;
            tick();
            tick();
            n_total++;
            if ({bus.result_valid, bus.result_data, bus.result_index} !== {1'b1, a_exp[i], 4'(i + 1)})
                $display("FAIL b2b_result_%0d: got %h want %h", i, {bus.result_valid, bus.result_data, bus.result_index},
                         {1'b1, a_exp[i], 4'(i + 1)});
            else n_pass++;
        end
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {bus.busy, bus.result_valid});
        else n_pass++;
    endtask

    task automatic test_pending;
        issue(4'd0, mk(OP_ADD, 5'd3, 5'd4, 13'd0), 4'd2, 32'hBAD, 4'd5, 32'd1, RDY);
        tick();
        bus.CDB_inst_fu = NONE;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({bus.busy, bus.result_valid} !== 2'b10) $display("FAIL pend_wait_%0d: got %b want 10", c, {bus.busy, bus.result_valid});
            else n_pass++;
            if (c == 1) slot(5, 32'd100, 1'b1);
            tick();
        end
        slot(5, 32'd0, 1'b0);
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid, bus.result_data, bus.result_index} !== {1'b0, 1'b1, 32'd101, 4'd2})
            $display("FAIL pend_result: got %h want %h", {bus.busy, bus.result_valid, bus.result_data, bus.result_index},
                     {1'b0, 1'b1, 32'd101, 4'd2});
        else n_pass++;
        issue(4'd0, mk(OP_ADD, 5'd3, 5'd4, 13'd0), 4'd1, 32'h111, 4'd6, 32'h222, 4'd6);
        tick();
        bus.CDB_inst_fu = NONE;
        slot(6, 32'd9, 1'b1);
        tick();
        slot(6, 32'd0, 1'b0);
        tick();
        tick();
        n_total++;
        if ({bus.result_valid, bus.result_data, bus.result_index} !== {1'b1, 32'd18, 4'd1})
            $display("FAIL same_tag: got %h want %h", {bus.result_valid, bus.result_data, bus.result_index}, {1'b1, 32'd18, 4'd1});
        else n_pass++;
        slot(7, 32'd40, 1'b1);
        issue(4'd0, mk(OP_ADD, 5'd3, 5'd4, 13'd0), 4'd4, 32'h333, 4'd7, 32'd2, RDY);
        tick();
        bus.CDB_inst_fu = NONE;
        slot(7, 32'd0, 1'b0);
        tick();
        tick();
        n_total++;
        if ({bus.result_valid, bus.result_data, bus.result_index} !== {1'b1, 32'd42, 4'd4})
            $display("FAIL bus_at_issue: got %h want %h", {bus.result_valid, bus.result_data, bus.result_index}, {1'b1, 32'd42, 4'd4});
        else n_pass++;
    endtask

    task automatic test_own_tag;
        issue(4'd0, mk(OP_ADD, 5'd3, 5'd4, 13'd0), 4'd4, 32'h0, 4'd4, 32'd1, RDY);
        slot(4, 32'd50, 1'b1);
        tick();
        bus.CDB_inst_fu = NONE;
        tick();
        tick();
        tick();
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b10) $display("FAIL own_tag: got %b want 10", {bus.busy, bus.result_valid});
        else n_pass++;
        slot(4, 32'd0, 1'b0);
        fu_reset = 1'b1;
        #1;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL own_tag_flush: got %b want 0", bus.busy);
        else n_pass++;
        fu_reset = 1'b0;
    endtask

    task automatic test_flush;
        issue(4'd0, mk(OP_ADD, 5'd1, 5'd2, 13'd0), 4'd5, 32'd1, RDY, 32'd1, RDY);
        tick();
        bus.CDB_inst_fu = NONE;
        tick();
        fu_reset = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b00) $display("FAIL flush_now: got %b want 00", {bus.busy, bus.result_valid});
        else n_pass++;
        #2 fu_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if ({bus.busy, bus.result_valid} !== 2'b00) $display("FAIL flush_after_%0d: got %b want 00", c, {bus.busy, bus.result_valid});
            else n_pass++;
        end
        issue(4'd0, mk(OP_ADD, 5'd1, 5'd2, 13'd0), 4'd6, 32'd10, RDY, 32'd20, RDY);
        tick();
        bus.CDB_inst_fu = NONE;
        tick();
        tick();
        n_total++;
        if ({bus.result_valid, bus.result_data, bus.result_index} !== {1'b1, 32'd30, 4'd6})
            $display("FAIL flush_next: got %h want %h", {bus.result_valid, bus.result_data, bus.result_index}, {1'b1, 32'd30, 4'd6});
        else n_pass++;
        tick();
    endtask

    task automatic test_ignore;
        issue(4'd1, mk(OP_ADD, 5'd1, 5'd2, 13'd0), 4'd3, 32'd5, RDY, 32'd7, RDY);
        #1;
        n_total++;
        if (numj === 5'd1 || numk === 5'd2) $display("FAIL other_fu_num: got %h want z", {numj, numk});
        else n_pass++;
        tick();
        bus.CDB_inst_fu = NONE;
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b00) $display("FAIL other_fu_state: got %b want 00", {bus.busy, bus.result_valid});
        else n_pass++;
        issue(4'd0, mk(OP_ADD, 5'd3, 5'd4, 13'd0), 4'd7, 32'h0, 4'd3, 32'd5, RDY);
        tick();
        issue(4'd0, mk(OP_SUB, 5'd9, 5'd10, 13'd0), 4'd1, 32'd1000, RDY, 32'd1, RDY);
        #1;
        n_total++;
        if (numj === 5'd9 || numk === 5'd10) $display("FAIL busy_num: got %h want z", {numj, numk});
        else n_pass++;
        tick();
        bus.CDB_inst_fu = NONE;
        n_total++;
        if ({bus.busy, bus.result_valid} !== 2'b10) $display("FAIL busy_state: got %b want 10", {bus.busy, bus.result_valid});
        else n_pass++;
        slot(3, 32'd10, 1'b1);
        tick();
        slot(3, 32'd0, 1'b0);
        tick();
        tick();
        n_total++;
        if ({bus.result_valid, bus.result_data, bus.result_index} !== {1'b1, 32'd15, 4'd7})
            $display("FAIL busy_kept: got %h want %h", {bus.result_valid, bus.result_data, bus.result_index}, {1'b1, 32'd15, 4'd7});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_pending();
        test_own_tag();
        test_flush();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
